ex_alu_stage: RTL and testbench
===============================

# ex_alu_stage

Execute-stage ALU block of the RV32I 5-stage pipeline. It consumes the 4-bit ALU control code produced in decode together with the two forwarded 32-bit operands and the destination register index. It computes the result and holds it in the EX/MEM pipeline register behind a valid/ready handshake. It sits between the ID/EX register (upstream) and the memory stage (downstream), and raises back-pressure when the output slot is occupied or a serial shift is in progress.

## Interface
- XLEN, 32, operand/result width (only 32 is supported)
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ID/EX presents an operation
- in_ready  output  1  stage can accept this cycle
- alu_ctrl  input  4  ALU control code (encoding below)
- op_a  input  XLEN  operand A (rs1 or PC, already forwarded)
- op_b  input  XLEN  operand B (rs2 or immediate, already forwarded)
- rd_in  input  5  destination register index
- flush  input  1  synchronous kill of in-flight and registered work
- out_valid  output  1  EX/MEM register holds a result
- out_ready  input  1  memory stage consumes the result
- result  output  XLEN  registered ALU result
- zero  output  1  registered (result == 0)
- rd_out  output  5  registered destination index

## Operation
- alu_ctrl encoding (fixed, shared with decode):
  - 0000 ADD; 1000 SUB
  - 1010 SLL; 0110 SRL; 1001 SRA
  - 1110 SLT (signed); 0001 SLTU
  - 0010 XOR; 1100 OR; 0100 AND
  - 1111 pass op_b (LUI)
  - any other code yields result 0
- Arithmetic: ADD/SUB wrap modulo 2^32, with no overflow flag. SLT/SLTU produce 32'd1 or 32'd0.
- Shift amount is always op_b[4:0]; op_b[31:5] is ignored.
- Accept: in_valid & in_ready at a rising edge. rd_in and all operands are captured in that cycle.
- in_ready = (state == IDLE) & (~out_valid | out_ready). It is combinational and is held low while flush is high.
- Output slot: loaded on completion. It is cleared when out_valid & out_ready and no new completion occurs in the same cycle. result, zero and rd_out stay stable while out_valid & ~out_ready.
- Flush: priority over accept and completion. It forces out_valid to 0 and state to IDLE on the next edge. A shift in progress is discarded and never appears on the output.
- Reset values: out_valid 0, result 0, zero 1, rd_out 0, state IDLE. in_ready is 1 after reset release.

## Timing
- Single-cycle ops: accept at edge N, so out_valid=1 and the result are visible after edge N. Latency is 1 cycle.
- Throughput is one op per cycle while out_ready is held high, because accept and drain happen in the same cycle.
- When out_ready is low with out_valid=1: in_ready=0, and in_valid/operands upstream must be held.
- With SERIAL_SHIFTER_EN, states are IDLE, SHIFT, DONE:
  - IDLE to SHIFT on accept of SLL/SRL/SRA with shamt ≠ 0. The counter is loaded with shamt.
  - SHIFT moves 1 bit per cycle and decrements the counter. It goes to DONE when the counter reaches 1 on the shifting edge.
  - DONE loads the output slot when it is free (~out_valid | out_ready), then returns to IDLE. Otherwise it waits in DONE.
  - Shift latency is shamt + 1 cycles to out_valid when the downstream stage is not stalled.
  - shamt = 0 completes in 1 cycle with no SHIFT entry.
  - in_ready = 0 in SHIFT and DONE.
- Reset asserted mid-shift: immediate return to IDLE, and the output is cleared asynchronously.

## Configuration
- SERIAL_SHIFTER_EN defined: shifts use the 1-bit-per-cycle iterative shifter and the SHIFT/DONE states above, for an area-reduced build.
- SERIAL_SHIFTER_EN undefined: a combinational barrel shifter is used, all ops take 1 cycle, and the state is permanently IDLE.
- Result values are identical in both builds; only latency and in_ready differ.

## Test plan
- Reset: hold rst_n=0, then release. Required: out_valid=0, result=0, zero=1, in_ready=1.
- Back-to-back ops with out_ready=1:
  - ADD 0x7FFFFFFF+1 gives 0x80000000.
  - SUB 5-5 gives 0 with zero=1.
  - SLT 0xFFFFFFFF<1 gives 1.
  - SLTU 0xFFFFFFFF<1 gives 0.
  - All four results appear on consecutive cycles.
- Back-pressure: out_ready=0 for 3 cycles after AND 0xF0F0_F0F0 & 0xFF00_FF00. Required: result holds 0xF000_F000, in_ready=0 for all 3 cycles, and the next op is accepted in the release cycle.
- SRA 0x80000000 by op_b=0x23 (shamt 3) gives 0xF0000000.
  - With SERIAL_SHIFTER_EN, out_valid appears 4 cycles after accept.
  - Without it, out_valid appears after 1 cycle.
- Flush mid-shift (SERIAL_SHIFTER_EN, SLL 1 by 20, flush at cycle 5). Required: no output from the shift, and in_ready=1 on the next cycle.
- Undefined alu_ctrl 0011 with any operands gives result=0, zero=1, and rd_out equal to the rd_in captured at accept.

Source files
------------

// File: rtl/ex_alu_stage.sv
// RV32I execute-stage ALU with an EX/MEM output slot behind a valid/ready handshake.
// Build option SERIAL_SHIFTER_EN: 1-bit-per-cycle shifter (IDLE/SHIFT/DONE) replaces the barrel shifter.
module ex_alu_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      rd_out
);

  localparam int unsigned SHW = 5;
  localparam int unsigned RDW = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1110;
  localparam logic [3:0] ALU_SLTU = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            accept;
  logic            slot_free;
  logic            drain;

  assign shamt     = op_b[SHW-1:0];
  assign slot_free = ~out_valid | out_ready;
  assign drain     = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

  // Single-cycle result; in the serial build a shift only reaches here with shamt == 0
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
`ifdef SERIAL_SHIFTER_EN
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
`else
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
`endif
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_LUI:  alu_res = op_b;
      default:  alu_res = '0;
    endcase
  end

`ifdef SERIAL_SHIFTER_EN

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] sh_val;
  logic [SHW-1:0]  sh_cnt;
  logic [3:0]      sh_op;
  logic [RDW-1:0]  sh_rd;
  logic            is_shift;
  logic            start_shift;

  assign is_shift    = (alu_ctrl == ALU_SLL) | (alu_ctrl == ALU_SRL) | (alu_ctrl == ALU_SRA);
  assign start_shift = accept & is_shift & (shamt != '0);
  assign in_ready    = ~flush & (state == ST_IDLE) & slot_free;

  // Control FSM, iterative shifter and EX/MEM slot; flush outranks everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      rd_out    <= '0;
      sh_val    <= '0;
      sh_cnt    <= '0;
      sh_op     <= '0;
      sh_rd     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_shift) begin
            state  <= ST_SHIFT;
            sh_val <= op_a;
            sh_cnt <= shamt;
            sh_op  <= alu_ctrl;
            sh_rd  <= rd_in;
            if (drain) out_valid <= 1'b0;
          end else if (accept) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            zero      <= (alu_res == '0);
            rd_out    <= rd_in;
          end else if (drain) begin
            out_valid <= 1'b0;
          end
        end
        ST_SHIFT: begin
          case (sh_op)
            ALU_SLL: sh_val <= sh_val << 1;
            ALU_SRL: sh_val <= sh_val >> 1;
            default: sh_val <= {sh_val[XLEN-1], sh_val[XLEN-1:1]};
          endcase
          sh_cnt <= sh_cnt - SHW'(1);
          if (sh_cnt == SHW'(1)) state <= ST_DONE;
          if (drain) out_valid <= 1'b0;
        end
        ST_DONE: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            result    <= sh_val;
            zero      <= (sh_val == '0);
            rd_out    <= sh_rd;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`else

  assign in_ready = ~flush & slot_free;

  // EX/MEM slot: load on accept, clear on drain, kill on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      rd_out    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
      rd_out    <= rd_in;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage: vector table, handshake corner sequences, random scoreboard.
module tb_ex_alu_stage;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b1010;
  localparam logic [3:0] C_SRL  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b1001;
  localparam logic [3:0] C_SLT  = 4'b1110;
  localparam logic [3:0] C_SLTU = 4'b0001;
  localparam logic [3:0] C_XOR  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b1100;
  localparam logic [3:0] C_AND  = 4'b0100;
  localparam logic [3:0] C_LUI  = 4'b1111;
  localparam logic [3:0] C_BAD  = 4'b0011;

`ifdef SERIAL_SHIFTER_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  localparam int N_RAND = 200;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, zero;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  rd_in, rd_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[14];
  exp_t q[$];
  int   issued  = 0;
  bit   pending = 1'b0;

  always #5 clk = ~clk;

  ex_alu_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
    .rd_out(rd_out)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values
  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p;
    int sh;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    p  = 1;
    for (int i = 0; i < sh; i++) p = p * 2;
    case (c)
      C_ADD:  return 32'(ua + ub);
      C_SUB:  return 32'(ua - ub);
      C_SLL:  return 32'(ua * p);
      C_SRL:  return 32'(ua / p);
      C_SRA:  return 32'((sa >= 0) ? (sa / p) : -((-sa + p - 1) / p));
      C_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      C_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
      C_XOR:  return a ^ b;
      C_OR:   return a | b;
      C_AND:  return a & b;
      C_LUI:  return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
    bit is_sh;
    int sh;
    is_sh = (c == C_SLL) || (c == C_SRL) || (c == C_SRA);
    sh    = int'(b[4:0]);
    return (SERIAL && is_sh && sh != 0) ? sh + 1 : 1;
  endfunction

  // Issue one op with out_ready high; report the output and cycles from accept to out_valid
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] r, output logic z,
                        output logic [4:0] rdo, output int lat);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL run_op_ready: got in_ready=0 expected 1 within 100 cycles");
    end
    alu_ctrl = c; op_a = a; op_b = b; rd_in = rd; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    r = result; z = zero; rdo = rd_out;
  endtask

  // Scoreboard sample taken after inputs settle, ahead of the next rising edge
  task automatic sb_sample();
    exp_t e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got out_valid=1 expected no pending result");
      end else begin
        e = q.pop_front();
        chk("sb_result", result, e.r);
        chk("sb_zero", {31'd0, zero}, {31'd0, (e.r == 32'd0)});
        chk("sb_rd", {27'd0, rd_out}, {27'd0, e.rd});
      end
    end
    if (in_valid && in_ready) begin
      e.r  = model(alu_ctrl, op_a, op_b);
      e.rd = rd_in;
      q.push_back(e);
      pending = 1'b0;
      issued++;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        z;
    logic [4:0]  rdo;
    int          lat;
    logic [3:0]  bc[4];
    logic [31:0] ba[4], bb[4], be[4];
    logic [3:0]  codes[12];
    int          cyc, cnt;

    vecs[0]  = '{C_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd1,  32'h8000_0000};
    vecs[1]  = '{C_SUB,  32'h0000_0005, 32'h0000_0005, 5'd2,  32'h0000_0000};
    vecs[2]  = '{C_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd3,  32'h0000_0001};
    vecs[3]  = '{C_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4,  32'h0000_0000};
    vecs[4]  = '{C_XOR,  32'h0F0F_0F0F, 32'hFFFF_0000, 5'd5,  32'hF0F0_0F0F};
    vecs[5]  = '{C_OR,   32'h1234_0000, 32'h0000_5678, 5'd6,  32'h1234_5678};
    vecs[6]  = '{C_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8,  32'hF000_F000};
    vecs[7]  = '{C_LUI,  32'h1111_1111, 32'hABCD_E000, 5'd9,  32'hABCD_E000};
    vecs[8]  = '{C_BAD,  32'h0000_1234, 32'h0000_5678, 5'd7,  32'h0000_0000};
    vecs[9]  = '{C_SRA,  32'h8000_0000, 32'h0000_0023, 5'd10, 32'hF000_0000};
    vecs[10] = '{C_SLL,  32'h0000_0001, 32'h0000_0014, 5'd11, 32'h0010_0000};
    vecs[11] = '{C_SRL,  32'h8000_0000, 32'h0000_001F, 5'd12, 32'h0000_0001};
    vecs[12] = '{C_SLL,  32'hDEAD_BEEF, 32'h0000_0020, 5'd13, 32'hDEAD_BEEF};
    vecs[13] = '{C_SUB,  32'h0000_0000, 32'h0000_0001, 5'd31, 32'hFFFF_FFFF};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; op_a = '0; op_b = '0; rd_in = '0;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].rd, r, z, rdo, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, (vecs[i].exp == 32'd0)});
      chk($sformatf("vec%0d_rd", i), {27'd0, rdo}, {27'd0, vecs[i].rd});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].c, vecs[i].b)));
    end

    // Back-to-back with out_ready high: results on consecutive cycles
    bc[0] = C_ADD;  ba[0] = 32'h7FFF_FFFF; bb[0] = 32'd1; be[0] = 32'h8000_0000;
    bc[1] = C_SUB;  ba[1] = 32'd5;         bb[1] = 32'd5; be[1] = 32'd0;
    bc[2] = C_SLT;  ba[2] = 32'hFFFF_FFFF; bb[2] = 32'd1; be[2] = 32'd1;
    bc[3] = C_SLTU; ba[3] = 32'hFFFF_FFFF; bb[3] = 32'd1; be[3] = 32'd0;
    @(negedge clk);
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i - 1), {31'd0, out_valid}, 32'd1);
        chk($sformatf("b2b%0d_result", i - 1), result, be[i - 1]);
        chk($sformatf("b2b%0d_zero", i - 1), {31'd0, zero}, {31'd0, (be[i - 1] == 32'd0)});
        chk($sformatf("b2b%0d_rd", i - 1), {27'd0, rd_out}, 32'(i + 19));
      end
      if (i < 4) begin
        alu_ctrl = bc[i]; op_a = ba[i]; op_b = bb[i]; rd_in = 5'(i + 20); in_valid = 1'b1;
        #1;
        chk($sformatf("b2b%0d_ready", i), {31'd0, in_ready}, 32'd1);
        @(negedge clk);
      end else begin
        in_valid = 1'b0;
      end
    end

    // Back-pressure: AND held three cycles, next op accepted in the release cycle
    @(negedge clk);
    out_ready = 1'b0;
    alu_ctrl = C_AND; op_a = 32'hF0F0_F0F0; op_b = 32'hFF00_FF00; rd_in = 5'd14; in_valid = 1'b1;
    #1;
    chk("bp_ready_first", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    alu_ctrl = C_ADD; op_a = 32'd2; op_b = 32'd3; rd_in = 5'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_result", k), result, 32'hF000_F000);
      chk($sformatf("bp%0d_rd", k), {27'd0, rd_out}, 32'd14);
      chk($sformatf("bp%0d_ready", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_result", result, 32'hF000_F000);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_result", result, 32'd5);
    chk("bp_next_rd", {27'd0, rd_out}, 32'd9);

    // Flush kills a registered result and blocks accept while high
    @(negedge clk);
    out_ready = 1'b0;
    alu_ctrl = C_ADD; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd3; in_valid = 1'b1;
    @(negedge clk);
    alu_ctrl = C_OR; op_a = 32'hFF; op_b = 32'h0; rd_in = 5'd4;
    flush = 1'b1;
    #1;
    chk("fl_valid_before", {31'd0, out_valid}, 32'd1);
    chk("fl_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_valid_after", {31'd0, out_valid}, 32'd0);
    chk("fl_ready_after", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

`ifdef SERIAL_SHIFTER_EN
    // Flush in the middle of SLL 1 by 20: the shift must never surface
    @(negedge clk);
    alu_ctrl = C_SLL; op_a = 32'd1; op_b = 32'd20; rd_in = 5'd15; in_valid = 1'b1;
    #1;
    chk("fs_ready_accept", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("fs_ready_busy", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fs_ready_after", {31'd0, in_ready}, 32'd1);
    chk("fs_valid_after", {31'd0, out_valid}, 32'd0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("fs_no_output", 32'(cnt), 32'd0);
`endif

    // Random traffic with random back-pressure against the reference model
    codes = '{C_ADD, C_SUB, C_SLL, C_SRL, C_SRA, C_SLT, C_SLTU, C_XOR, C_OR, C_AND, C_LUI, C_BAD};
    q.delete();
    issued = 0;
    pending = 1'b0;
    cyc = 0;
    while (issued < N_RAND && cyc < 15000) begin
      @(negedge clk);
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          alu_ctrl = codes[$urandom_range(0, 11)];
          op_a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
          op_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
          rd_in    = 5'($urandom_range(0, 31));
          in_valid = 1'b1;
          pending  = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      sb_sample();
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 200) begin
      #1;
      sb_sample();
      @(negedge clk);
      cyc++;
    end
    chk("sb_issued", 32'(issued), 32'(N_RAND));
    chk("sb_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
